// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter for a single-port 32-bit on-chip RAM. Commands are registered onto the RAM port and read data is returned through a two-stage owner tag pipeline.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; left undefined, m0 has fixed priority.
module onchip_mem_arbiter #(
    parameter int          DEPTH    = 5000,
    parameter int          AW       = 13,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic          clk,
    input  logic          reset,

    input  logic [AW-1:0] m0_address,
    input  logic [3:0]    m0_byteenable,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [31:0]   m0_writedata,
    output logic          m0_waitrequest,
    output logic [31:0]   m0_readdata,
    output logic          m0_readdatavalid,

    input  logic [AW-1:0] m1_address,
    input  logic [3:0]    m1_byteenable,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [31:0]   m1_writedata,
    output logic          m1_waitrequest,
    output logic [31:0]   m1_readdata,
    output logic          m1_readdatavalid,

    input  logic          freeze,

    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,

    output logic          err_flag
);

    typedef struct packed {
        logic valid;
        logic owner;   // 0 = m0, 1 = m1
        logic oob;
    } tag_t;

    // One extra bit so DEPTH == 2**AW still fits.
    localparam logic [AW:0] DEPTH_LIMIT = (AW + 1)'(DEPTH);

    logic          m0_req;
    logic          m1_req;
    logic          gnt0;
    logic          gnt1;
    logic          any_gnt;

    logic [AW-1:0] cmd_address;
    logic [3:0]    cmd_byteenable;
    logic [31:0]   cmd_writedata;
    logic          cmd_write;
    logic          cmd_oob;

    tag_t          stage1;
    tag_t          stage2;
    logic [31:0]   ret_data;
    logic [31:0]   m0_hold;
    logic [31:0]   m1_hold;

    assign m0_req  = m0_read | m0_write;
    assign m1_req  = m1_read | m1_write;
    assign any_gnt = gnt0 | gnt1;

    // NOTE: each always_comb assigns every output a default before any branch, so no path can infer a latch.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic prefer_m1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!freeze) begin
            if (m0_req && m1_req) begin
                gnt0 = !prefer_m1;
                gnt1 = prefer_m1;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    // After any grant the preference passes to the master that was not served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefer_m1 <= 1'b0;
        end else if (any_gnt) begin
            prefer_m1 <= gnt0;
        end
    end
`else
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!freeze) begin
            gnt0 = m0_req;
            gnt1 = m1_req & ~m0_req;
        end
    end
`endif

    assign m0_waitrequest = m0_req & ~gnt0;
    assign m1_waitrequest = m1_req & ~gnt1;

    // Write wins when read and write are raised together.
    assign cmd_address    = gnt1 ? m1_address    : m0_address;
    assign cmd_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    assign cmd_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    assign cmd_write      = gnt1 ? m1_write      : m0_write;
    assign cmd_oob        = {1'b0, cmd_address} >= DEPTH_LIMIT;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            stage1         <= '0;
            stage2         <= '0;
            err_flag       <= 1'b0;
            m0_hold        <= '0;
            m1_hold        <= '0;
        end else begin
            // An out-of-range slot is accepted but never reaches the RAM.
            mem_chipselect <= any_gnt & ~cmd_oob;
            mem_write      <= any_gnt & cmd_write & ~cmd_oob;
            if (any_gnt) begin
                mem_address    <= cmd_address;
                mem_byteenable <= cmd_byteenable;
                mem_writedata  <= cmd_writedata;
            end

            stage1 <= '{valid: any_gnt & ~cmd_write, owner: gnt1, oob: cmd_oob};
            stage2 <= stage1;

            if (any_gnt && cmd_oob) begin
                err_flag <= 1'b1;
            end

            if (m0_readdatavalid) begin
                m0_hold <= ret_data;
            end
            if (m1_readdatavalid) begin
                m1_hold <= ret_data;
            end
        end
    end

    // RAM q is unregistered, so returned data is steered combinationally in the return cycle and held afterwards.
    assign ret_data         = stage2.oob ? ERR_WORD : mem_readdata;
    assign m0_readdatavalid = stage2.valid & ~stage2.owner;
    assign m1_readdatavalid = stage2.valid &  stage2.owner;
    assign m0_readdata      = m0_readdatavalid ? ret_data : m0_hold;
    assign m1_readdata      = m1_readdatavalid ? ret_data : m1_hold;

    assign mem_clken = 1'b1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: a RAM stand-in, a transaction-level reference model checked every cycle, directed scenarios and a randomized phase.
// Build with MEM_ARB_ROUND_ROBIN_EN defined to check the round-robin variant.
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;

    localparam int          DEPTH    = 5000;
    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] m0_address = '0;
    logic [3:0]  m0_byteenable = '0;
    logic        m0_read = 1'b0;
    logic        m0_write = 1'b0;
    logic [31:0] m0_writedata = '0;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [12:0] m1_address = '0;
    logic [3:0]  m1_byteenable = '0;
    logic        m1_read = 1'b0;
    logic        m1_write = 1'b0;
    logic [31:0] m1_writedata = '0;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;
    logic        freeze = 1'b0;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic        err_flag;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .freeze(freeze),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .err_flag(err_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // RAM stand-in: registered address, unregistered q, byte-lane writes.
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_q = '0;
    bit          ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
            ram_ready <= 1'b1;
        end else if (mem_chipselect && mem_clken && int'(mem_address) < DEPTH) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_q;

    // Reference model: each accepted command is applied to a shadow memory in acceptance order,
    // and a read schedules its return (owner, data) for the accept cycle + 2.
    typedef struct { int due; bit owner; logic [31:0] data; } ret_t;
    ret_t        pend[$];
    logic [31:0] model_mem [DEPTH];
    bit          model_ready = 1'b0;
    bit          m_ptr = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] held [2] = '{32'h0, 32'h0};
    bit          exp_cs = 1'b0;
    bit          exp_we = 1'b0;
    logic [12:0] exp_addr = '0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_wd = '0;

    always @(negedge clk) begin : model_cmp
        bit          r0, r1, g0, g1, wr, oob;
        bit [1:0]    ev;
        logic [31:0] ed [2];
        logic [31:0] wd, rdata;
        logic [3:0]  be;
        logic [12:0] a;
        ret_t        e;
        if (!model_ready) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = pat(i);
            model_ready = 1'b1;
        end
        if (reset) begin
            pend.delete();
            exp_cs = 1'b0; exp_we = 1'b0; m_err = 1'b0; m_ptr = 1'b0;
            held[0] = '0; held[1] = '0;
        end else begin
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            g0 = 1'b0; g1 = 1'b0;
            if (!freeze) begin
                if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    g1 = m_ptr; g0 = !m_ptr;
`else
                    g0 = 1'b1;
`endif
                end else begin
                    g0 = r0; g1 = r1;
                end
            end
            check("m0_waitrequest", 32'(m0_waitrequest), 32'(r0 && !g0));
            check("m1_waitrequest", 32'(m1_waitrequest), 32'(r1 && !g1));
            check("mem_chipselect", 32'(mem_chipselect), 32'(exp_cs));
            check("mem_write", 32'(mem_write), 32'(exp_we));
            if (exp_cs) check("mem_address", 32'(mem_address), 32'(exp_addr));
            if (exp_we) begin
                check("mem_byteenable", 32'(mem_byteenable), 32'(exp_be));
                check("mem_writedata", mem_writedata, exp_wd);
            end
            check("err_flag", 32'(err_flag), 32'(m_err));

            ev = '0; ed[0] = '0; ed[1] = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e = pend.pop_front();
                ev[e.owner] = 1'b1;
                ed[e.owner] = e.data;
            end
            check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(ev[0]));
            check("m0_readdata", m0_readdata, ev[0] ? ed[0] : held[0]);
            check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(ev[1]));
            check("m1_readdata", m1_readdata, ev[1] ? ed[1] : held[1]);
            if (ev[0]) held[0] = ed[0];
            if (ev[1]) held[1] = ed[1];

            if (g0 || g1) begin
                a   = g1 ? m1_address : m0_address;
                wr  = g1 ? m1_write : m0_write;
                be  = g1 ? m1_byteenable : m0_byteenable;
                wd  = g1 ? m1_writedata : m0_writedata;
                oob = int'(a) >= DEPTH;
                exp_cs = !oob; exp_we = wr && !oob;
                exp_addr = a; exp_be = be; exp_wd = wd;
                if (oob) m_err = 1'b1;
                if (!wr) begin
                    rdata = ERR_WORD;
                    if (!oob) rdata = model_mem[a];
                    pend.push_back('{due: cyc + 2, owner: g1, data: rdata});
                end else if (!oob) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model_mem[a][8*b +: 8] = wd[8*b +: 8];
                end
                m_ptr = g0;
            end else begin
                exp_cs = 1'b0; exp_we = 1'b0;
            end
        end
    end

    // Observation of returns and handshakes for the directed checks and the stimulus driver.
    int          last_rdv_cyc [2] = '{-1, -1};
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};
    int          rdv_cnt [2] = '{0, 0};
    int          cs_cnt = 0;
    logic        w_neg [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        if (m0_readdatavalid) begin
            last_rdv_cyc[0] <= cyc; last_rd[0] <= m0_readdata; rdv_cnt[0] <= rdv_cnt[0] + 1;
        end
        if (m1_readdatavalid) begin
            last_rdv_cyc[1] <= cyc; last_rd[1] <= m1_readdata; rdv_cnt[1] <= rdv_cnt[1] + 1;
        end
        if (mem_chipselect) cs_cnt <= cs_cnt + 1;
        w_neg[0] <= m0_waitrequest;
        w_neg[1] <= m1_waitrequest;
    end

    task automatic set_master(input int m, input bit rd, input bit wr, input logic [12:0] a,
                              input logic [3:0] be, input logic [31:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    // Called just after a rising edge; returns the accept cycle and leaves the master idle.
    task automatic issue(input int m, input bit wr, input logic [12:0] a, input logic [3:0] be,
                         input logic [31:0] d, output int t);
        bit acc;
        set_master(m, !wr, wr, a, be, d);
        t = -1;
        for (int k = 0; k < 40 && t < 0; k++) begin
            @(negedge clk);
            acc = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
            if (acc) t = cyc;
            @(posedge clk);
            #1;
        end
        set_master(m, 1'b0, 1'b0, '0, '0, '0);
        if (t < 0) check("issue_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t, t2, c, c0, c1, exp0, exp1, sel;
        bit          busy, rd, wr;
        logic [12:0] a;

        @(negedge clk);
        check("rst_m0_rdv", 32'(m0_readdatavalid), 32'(0));
        check("rst_m0_rdata", m0_readdata, 32'h0);
        check("rst_mem_cs", 32'(mem_chipselect), 32'(0));
        check("rst_err", 32'(err_flag), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Write then immediate read of the same word by m0.
        c1 = rdv_cnt[1];
        issue(0, 1'b1, 13'd10, 4'hF, 32'h12345678, t);
        issue(0, 1'b0, 13'd10, 4'h0, 32'h0, t2);
        idle(3);
        check("t1_read_follows_write", 32'(t2), 32'(t + 1));
        check("t1_rdv_latency", 32'(last_rdv_cyc[0]), 32'(t2 + 2));
        check("t1_rdata", last_rd[0], 32'h12345678);
        check("t1_m1_quiet", 32'(rdv_cnt[1]), 32'(c1));

        // Continuous dual reads for six cycles.
        issue(0, 1'b1, 13'd1, 4'hF, 32'h0000000A, t);
        issue(1, 1'b1, 13'd2, 4'hF, 32'h0000000B, t);
        idle(3);
        c0 = rdv_cnt[0]; c1 = rdv_cnt[1];
        set_master(0, 1'b1, 1'b0, 13'd1, 4'h0, 32'h0);
        set_master(1, 1'b1, 1'b0, 13'd2, 4'h0, 32'h0);
        idle(6);
        set_master(0, 1'b0, 1'b0, '0, '0, '0);
        set_master(1, 1'b0, 1'b0, '0, '0, '0);
        idle(4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp0 = 3; exp1 = 3;
`else
        exp0 = 6; exp1 = 0;
`endif
        check("t2_m0_returns", 32'(rdv_cnt[0] - c0), 32'(exp0));
        check("t2_m1_returns", 32'(rdv_cnt[1] - c1), 32'(exp1));
        check("t2_m0_data", last_rd[0], 32'h0000000A);

        // Single byte lane write into a cleared word.
        issue(0, 1'b1, 13'd20, 4'hF, 32'h00000000, t);
        issue(0, 1'b1, 13'd20, 4'b0010, 32'hFFFFFFFF, t);
        issue(0, 1'b0, 13'd20, 4'h0, 32'h0, t);
        idle(3);
        check("t3_byte_lane", last_rd[0], 32'h0000FF00);

        // Out-of-range commands from m1, then the last valid word.
        check("t4_err_before", 32'(err_flag), 32'(0));
        c = cs_cnt;
        issue(1, 1'b0, 13'd5000, 4'h0, 32'h0, t);
        issue(1, 1'b1, 13'd8191, 4'hF, 32'h11111111, t2);
        idle(3);
        check("t4_oob_rdv_cycle", 32'(last_rdv_cyc[1]), 32'(t + 2));
        check("t4_oob_rdata", last_rd[1], 32'hDEADBEEF);
        check("t4_err_set", 32'(err_flag), 32'(1));
        check("t4_no_chipselect", 32'(cs_cnt - c), 32'(0));
        issue(1, 1'b1, 13'd4999, 4'hF, 32'hCAFE0001, t);
        issue(1, 1'b0, 13'd4999, 4'h0, 32'h0, t);
        idle(3);
        check("t4_last_word", last_rd[1], 32'hCAFE0001);

        // freeze raised the cycle after a read is accepted.
        issue(0, 1'b0, 13'd10, 4'h0, 32'h0, t);
        freeze = 1'b1;
        set_master(0, 1'b1, 1'b0, 13'd1, 4'h0, 32'h0);
        set_master(1, 1'b1, 1'b0, 13'd2, 4'h0, 32'h0);
        @(negedge clk);
        check("t5_m0_wait_frozen", 32'(m0_waitrequest), 32'(1));
        check("t5_m1_wait_frozen", 32'(m1_waitrequest), 32'(1));
        idle(3);
        check("t5_inflight_rdv", 32'(last_rdv_cyc[0]), 32'(t + 2));
        check("t5_inflight_data", last_rd[0], 32'h12345678);
        freeze = 1'b0;
        c = rdv_cnt[0] + rdv_cnt[1];
        idle(2);
        set_master(0, 1'b0, 1'b0, '0, '0, '0);
        set_master(1, 1'b0, 1'b0, '0, '0, '0);
        idle(4);
        check("t5_resumed", 32'(rdv_cnt[0] + rdv_cnt[1] - c), 32'(2));

        // Reset one cycle after a read is accepted.
        c = rdv_cnt[0] + rdv_cnt[1];
        issue(0, 1'b0, 13'd1, 4'h0, 32'h0, t);
        reset = 1'b1;
        #1;
        check("t6_rdv0", 32'(m0_readdatavalid), 32'(0));
        check("t6_rdv1", 32'(m1_readdatavalid), 32'(0));
        check("t6_rdata0", m0_readdata, 32'h0);
        check("t6_rdata1", m1_readdata, 32'h0);
        check("t6_mem_cs", 32'(mem_chipselect), 32'(0));
        check("t6_mem_write", 32'(mem_write), 32'(0));
        check("t6_mem_addr", 32'(mem_address), 32'(0));
        check("t6_mem_be", 32'(mem_byteenable), 32'(0));
        check("t6_mem_wd", mem_writedata, 32'h0);
        check("t6_err", 32'(err_flag), 32'(0));
        idle(2);
        reset = 1'b0;
        idle(3);
        check("t6_no_return", 32'(rdv_cnt[0] + rdv_cnt[1]), 32'(c));

        // Random traffic; a master holds its command until it is accepted.
        for (int i = 0; i < 1500; i++) begin
            for (int m = 0; m < 2; m++) begin
                busy = (m == 0) ? (m0_read | m0_write) : (m1_read | m1_write);
                if (!busy || !w_neg[m]) begin
                    sel = int'($urandom_range(0, 9));
                    rd  = (sel >= 3 && sel <= 5) || sel == 9;
                    wr  = sel >= 6;
                    if ($urandom_range(0, 9) < 8) a = 13'($urandom_range(0, 15));
                    else if ($urandom_range(0, 3) == 0) a = 13'h1FFF;
                    else a = 13'($urandom_range(4990, 5010));
                    set_master(m, rd, wr, a, 4'($urandom), $urandom);
                end
            end
            freeze = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end
        freeze = 1'b0;
        set_master(0, 1'b0, 1'b0, '0, '0, '0);
        set_master(1, 1'b0, 1'b0, '0, '0, '0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
